regfile_write_arbiter: RTL and testbench

//   Shares the register file's single write port (write/dataSelect/dataIn) between two

---
 rtl/regfile_write_arbiter_if.sv | 14 +
 rtl/regfile_write_arbiter.sv | 138 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request channel: one requester offering a register-file write
// through a valid/ready handshake.
interface regfile_write_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  valid;
  logic                  ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output addr, output data, input  ready);
  modport slave  (input  valid, input  addr, input  data, output ready);
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between the ALU (A) and load (B)
// writeback paths: one-entry buffers, round-robin grant, same-register ordering.
module regfile_write_arbiter #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned ZERO_REG   = 31,
  parameter int unsigned STALL_W    = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  regfile_write_arbiter_if.slave a,
  regfile_write_arbiter_if.slave b,
  output logic                  rf_write,
  output logic [ADDR_WIDTH-1:0] rf_dataSelect,
  output logic [DATA_WIDTH-1:0] rf_dataIn,
  output logic [31:0]           pending,
  output logic [STALL_W-1:0]    stall_count
);

  localparam int unsigned NUM_REGS = 32;

  logic                  a_full_q, a_full_d, b_full_q, b_full_d;
  logic [ADDR_WIDTH-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic [DATA_WIDTH-1:0] a_data_q, a_data_d, b_data_q, b_data_d;
  logic                  rr_q, rr_d;     // 0: A next on contention, 1: B next
  logic                  age_q, age_d;   // 0: A older, 1: B older
  logic [ADDR_WIDTH-1:0] last_sel_q, last_sel_d;
  logic [DATA_WIDTH-1:0] last_data_q, last_data_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;
  logic [STALL_W-1:0]    stall_q, stall_d;

  logic a_fill, b_fill, gnt_a, gnt_b, both_full, same_addr, stall_inc;

  assign a.ready = ~a_full_q;
  assign b.ready = ~b_full_q;

  // Accepted writes to the zero register finish the handshake but are dropped.
  assign a_fill = a.valid & ~a_full_q & (a.addr != ADDR_WIDTH'(ZERO_REG));
  assign b_fill = b.valid & ~b_full_q & (b.addr != ADDR_WIDTH'(ZERO_REG));

  assign both_full = a_full_q & b_full_q;
  assign same_addr = (a_addr_q == b_addr_q);

  // Grant: same register goes to the older entry, otherwise round-robin.
  always_comb begin
    gnt_a = a_full_q;
    gnt_b = b_full_q;
    if (both_full) begin
      gnt_a = same_addr ? ~age_q : ~rr_q;
      gnt_b = ~gnt_a;
    end
  end

  assign stall_inc = (a_full_q & ~gnt_a) | (b_full_q & ~gnt_b);

  // Next-state for buffers, arbitration state, pending mask and stall counter.
  always_comb begin
    a_full_d    = a_fill | (a_full_q & ~gnt_a);
    b_full_d    = b_fill | (b_full_q & ~gnt_b);
    a_addr_d    = a_fill ? a.addr : a_addr_q;
    b_addr_d    = b_fill ? b.addr : b_addr_q;
    a_data_d    = a_fill ? a.data : a_data_q;
    b_data_d    = b_fill ? b.data : b_data_q;
    rr_d        = rr_q;
    age_d       = age_q;
    last_sel_d  = last_sel_q;
    last_data_d = last_data_q;
    stall_d     = stall_q;
    pending_d   = '0;

    if (both_full && !same_addr) rr_d = gnt_a;

    if (a_fill && b_fill) age_d = 1'b0;
    else if (a_fill)      age_d = 1'b1;
    else if (b_fill)      age_d = 1'b0;

    if (rf_write) begin
      last_sel_d  = rf_dataSelect;
      last_data_d = rf_dataIn;
    end

    if (stall_inc && (stall_q != {STALL_W{1'b1}})) stall_d = stall_q + STALL_W'(1);

    if (a_full_d) pending_d[a_addr_d] = 1'b1;
    if (b_full_d) pending_d[b_addr_d] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_full_q    <= 1'b0;
      b_full_q    <= 1'b0;
      a_addr_q    <= '0;
      b_addr_q    <= '0;
      rr_q        <= 1'b0;
      age_q       <= 1'b0;
      last_sel_q  <= '0;
      last_data_q <= '0;
      pending_q   <= '0;
      stall_q     <= '0;
    end else begin
      a_full_q    <= a_full_d;
      b_full_q    <= b_full_d;
      a_addr_q    <= a_addr_d;
      b_addr_q    <= b_addr_d;
      rr_q        <= rr_d;
      age_q       <= age_d;
      last_sel_q  <= last_sel_d;
      last_data_q <= last_data_d;
      pending_q   <= pending_d;
      stall_q     <= stall_d;
    end
  end

  // Payload registers only matter while the matching full flag is set.
  always_ff @(posedge clock) begin
    a_data_q <= a_data_d;
    b_data_q <= b_data_d;
  end

  // Write port follows the grant in the same cycle; held values otherwise.
  // Reset suppresses the write so buffered entries are never committed.
  always_comb begin
    rf_write      = (gnt_a | gnt_b) & ~reset;
    rf_dataSelect = last_sel_q;
    rf_dataIn     = last_data_q;
    if (gnt_a) begin
      rf_dataSelect = a_addr_q;
      rf_dataIn     = a_data_q;
    end else if (gnt_b) begin
      rf_dataSelect = b_addr_q;
      rf_dataIn     = b_data_q;
    end
  end

  assign pending     = pending_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: expected commits are queued at issue time and a negedge
// monitor pops and compares every register-file write the arbiter presents.
module tb_regfile_write_arbiter;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 5;
  localparam int unsigned SW = 8;   // narrow counter so saturation is reachable quickly

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } commit_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          rf_write;
  logic [AW-1:0] rf_dataSelect;
  logic [DW-1:0] rf_dataIn;
  logic [31:0]   pending;
  logic [SW-1:0] stall_count;

  regfile_write_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a_if ();
  regfile_write_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b_if ();

  regfile_write_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(31), .STALL_W(SW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .a             (a_if),
    .b             (b_if),
    .rf_write      (rf_write),
    .rf_dataSelect (rf_dataSelect),
    .rf_dataIn     (rf_dataIn),
    .pending       (pending),
    .stall_count   (stall_count)
  );

  always #5 clock = ~clock;

  int      n_total = 0;
  int      n_pass  = 0;
  commit_t exp_q[$];
  logic [DW-1:0] rf_model [32];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_exp(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    commit_t c;
    c.addr = addr;
    c.data = data;
    exp_q.push_back(c);
  endtask

  // Register file the arbiter drives; r31 is hardwired to zero.
  initial for (int i = 0; i < 32; i++) rf_model[i] = '0;
  always @(posedge clock)
    if (rf_write === 1'b1 && rf_dataSelect != 5'd31) rf_model[rf_dataSelect] <= rf_dataIn;

  // Monitor: every write seen must be the next expected commit.
  always @(negedge clock) begin
    if (rf_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected no write",
                 rf_dataSelect, rf_dataIn);
      end else begin
        commit_t c;
        c = exp_q.pop_front();
        check("commit_addr", DW'(rf_dataSelect), DW'(c.addr));
        check("commit_data", rf_dataIn, c.data);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Present A and/or B for exactly one edge; both must already be ready.
  task automatic issue(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    if (av) check("a_ready_at_issue", DW'(a_if.ready), DW'(1));
    if (bv) check("b_ready_at_issue", DW'(b_if.ready), DW'(1));
    a_if.valid = av; a_if.addr = aa; a_if.data = ad;
    b_if.valid = bv; b_if.addr = ba; b_if.data = bd;
    @(posedge clock);
    #1;
    a_if.valid = 1'b0;
    b_if.valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    a_if.valid = 1'b0; a_if.addr = '0; a_if.data = '0;
    b_if.valid = 1'b0; b_if.addr = '0; b_if.data = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_a_ready", DW'(a_if.ready), DW'(1));
    check("rst_b_ready", DW'(b_if.ready), DW'(1));
    check("rst_rf_write", DW'(rf_write), DW'(0));
    check("rst_sel", DW'(rf_dataSelect), DW'(0));
    check("rst_din", rf_dataIn, DW'(0));
    check("rst_pending", DW'(pending), DW'(0));
    check("rst_stall", DW'(stall_count), DW'(0));

    // Single uncontested write
    push_exp(5'd3, 64'h1234);
    issue(1'b1, 5'd3, 64'h1234, 1'b0, '0, '0);
    check("t1_pending_set", DW'(pending), DW'(32'h8));
    check("t1_a_ready_low", DW'(a_if.ready), DW'(0));
    check("t1_rf_write", DW'(rf_write), DW'(1));
    idle(1);
    check("t1_pending_clr", DW'(pending), DW'(0));
    check("t1_a_ready_back", DW'(a_if.ready), DW'(1));
    check("t1_r3", rf_model[3], 64'h1234);
    check("t1_no_write", DW'(rf_write), DW'(0));
    check("t1_sel_hold", DW'(rf_dataSelect), DW'(3));
    check("t1_din_hold", rf_dataIn, 64'h1234);

    // Simultaneous accepts, different registers: A first, then round-robin B first
    push_exp(5'd5, 64'd1);
    push_exp(5'd6, 64'd2);
    issue(1'b1, 5'd5, 64'd1, 1'b1, 5'd6, 64'd2);
    check("t2_pending_both", DW'(pending), DW'(32'h60));
    check("t2_stall0", DW'(stall_count), DW'(0));
    idle(1);
    check("t2_stall1", DW'(stall_count), DW'(1));
    check("t2_pending_b", DW'(pending), DW'(32'h40));
    check("t2_a_ready", DW'(a_if.ready), DW'(1));
    check("t2_b_busy", DW'(b_if.ready), DW'(0));
    idle(1);
    check("t2_r5", rf_model[5], 64'd1);
    check("t2_r6", rf_model[6], 64'd2);
    push_exp(5'd6, 64'd4);
    push_exp(5'd5, 64'd3);
    issue(1'b1, 5'd5, 64'd3, 1'b1, 5'd6, 64'd4);
    idle(2);
    check("t2_stall2", DW'(stall_count), DW'(2));
    check("t2_r5b", rf_model[5], 64'd3);
    check("t2_r6b", rf_model[6], 64'd4);

    // Same register, staggered: B then A, A's value survives
    push_exp(5'd7, 64'd9);
    push_exp(5'd7, 64'd8);
    issue(1'b0, '0, '0, 1'b1, 5'd7, 64'd9);
    issue(1'b1, 5'd7, 64'd8, 1'b0, '0, '0);
    idle(1);
    check("t3_r7", rf_model[7], 64'd8);
    check("t3_stall", DW'(stall_count), DW'(2));

    // Contested pair moves the pointer to B; then same register must still favour older A
    push_exp(5'd10, 64'hA);
    push_exp(5'd11, 64'hB);
    issue(1'b1, 5'd10, 64'hA, 1'b1, 5'd11, 64'hB);
    idle(2);
    push_exp(5'd12, 64'h55);
    push_exp(5'd12, 64'h66);
    issue(1'b1, 5'd12, 64'h55, 1'b1, 5'd12, 64'h66);
    idle(2);
    check("t3_stall4", DW'(stall_count), DW'(4));
    check("t3_r12", rf_model[12], 64'h66);

    // Zero register write is accepted and dropped
    issue(1'b1, 5'd31, 64'hFFFF, 1'b0, '0, '0);
    check("t4_a_ready", DW'(a_if.ready), DW'(1));
    check("t4_pending", DW'(pending), DW'(0));
    check("t4_no_write", DW'(rf_write), DW'(0));
    idle(2);
    check("t4_r31", rf_model[31], 64'h0);
    check("t4_sel_hold", DW'(rf_dataSelect), DW'(12));

    // Reset with both buffers full discards them
    issue(1'b1, 5'd1, 64'hAA, 1'b1, 5'd2, 64'hBB);
    check("t5_pending_full", DW'(pending), DW'(32'h6));
    reset = 1'b1;
    #1;
    check("t5_write_gated", DW'(rf_write), DW'(0));
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("t5_rf_write", DW'(rf_write), DW'(0));
    check("t5_a_ready", DW'(a_if.ready), DW'(1));
    check("t5_b_ready", DW'(b_if.ready), DW'(1));
    check("t5_pending", DW'(pending), DW'(0));
    check("t5_stall", DW'(stall_count), DW'(0));
    check("t5_sel", DW'(rf_dataSelect), DW'(0));
    idle(2);
    check("t5_r1", rf_model[1], 64'h0);
    check("t5_r2", rf_model[2], 64'h0);
    check("t5_r3_kept", rf_model[3], 64'h1234);

    // Pointer is back at A after reset
    push_exp(5'd20, 64'h20);
    push_exp(5'd21, 64'h21);
    issue(1'b1, 5'd20, 64'h20, 1'b1, 5'd21, 64'h21);
    idle(2);
    check("t5_stall_after", DW'(stall_count), DW'(1));

    // Repeated contention drives the stall counter into saturation
    for (int i = 0; i < 300; i++) begin
      push_exp(5'd8, DW'(i));
      push_exp(5'd8, DW'(i + 1000));
      issue(1'b1, 5'd8, DW'(i), 1'b1, 5'd8, DW'(i + 1000));
      idle(2);
      if (i == 99) check("t6_stall_mid", DW'(stall_count), DW'(101));
    end
    check("t6_stall_sat", DW'(stall_count), DW'(255));
    check("t6_r8", rf_model[8], DW'(1299));

    idle(2);
    check("scoreboard_empty", DW'(exp_q.size()), DW'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
